// File: rtl/vote_pkg.sv
// Shared types and sizes for the ballot controller and the vote logger.
package vote_pkg;

  localparam int NUM_CAND = 4;
  localparam int VOTE_W   = 8;

  typedef logic [$clog2(NUM_CAND)-1:0] cand_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HOLD,
    ISSUE,
    LOCKOUT
  } state_t;

  // Index of the highest pressed button; callers only use it on one-hot input.
  function automatic cand_idx_t btn_to_idx(input logic [NUM_CAND-1:0] btn);
    cand_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (btn[i]) idx = cand_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ballot_controller_if.sv
// Voter-panel and logger signals of the ballot controller.
interface ballot_controller_if;
  import vote_pkg::*;

  logic              mode;
  logic              ballot_start;
  logic              button1;
  logic              button2;
  logic              button3;
  logic              button4;
  logic              cand1_vote_valid;
  logic              cand2_vote_valid;
  logic              cand3_vote_valid;
  logic              cand4_vote_valid;
  logic              ballot_open;
  logic              busy;
  logic              multi_press_err;
  logic [VOTE_W-1:0] total_votes;

  modport master (
    output mode, ballot_start, button1, button2, button3, button4,
    input  cand1_vote_valid, cand2_vote_valid, cand3_vote_valid, cand4_vote_valid,
    input  ballot_open, busy, multi_press_err, total_votes
  );

  modport slave (
    input  mode, ballot_start, button1, button2, button3, button4,
    output cand1_vote_valid, cand2_vote_valid, cand3_vote_valid, cand4_vote_valid,
    output ballot_open, busy, multi_press_err, total_votes
  );

endinterface

// File: rtl/ballot_timer.sv
// Clear/increment counter with equality compare; clr together with inc restarts at 1.
module ballot_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = (cnt == limit);

endmodule

// File: rtl/ballot_controller.sv
// Voting-booth controller: authorises one ballot, qualifies a single held button,
// issues one vote pulse and then waits for the panel to be fully released.
module ballot_controller
  import vote_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int LOCKOUT_CYCLES = 8
) (
  input  logic           clock,
  input  logic           reset,
  ballot_controller_if.slave bus
);

  localparam logic [15:0] HOLD_LIM = 16'(HOLD_CYCLES);
  localparam logic [15:0] LOCK_LIM = 16'(LOCKOUT_CYCLES - 1);

  state_t            state, state_nx;
  cand_idx_t         idx, idx_nx;
  logic              err_q, err_nx;
  logic [VOTE_W-1:0] total;
  logic [NUM_CAND-1:0] btn;
  logic [NUM_CAND-1:0] vote;
  logic              single, latched_only, any_btn;
  logic              hold_clr, hold_inc, hold_hit;
  logic              lock_clr, lock_inc, lock_hit;
  logic              count_vote;

  assign btn          = {bus.button4, bus.button3, bus.button2, bus.button1};
  assign any_btn      = (btn != '0);
  assign single       = any_btn && ((btn & (btn - NUM_CAND'(1))) == '0);
  assign latched_only = (btn == (NUM_CAND'(1) << idx));

  ballot_timer #(.CNT_W(16)) u_hold (
    .clock (clock),
    .reset (reset),
    .clr   (hold_clr),
    .inc   (hold_inc),
    .limit (HOLD_LIM),
    .hit   (hold_hit)
  );

  ballot_timer #(.CNT_W(16)) u_lock (
    .clock (clock),
    .reset (reset),
    .clr   (lock_clr),
    .inc   (lock_inc),
    .limit (LOCK_LIM),
    .hit   (lock_hit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      err_q <= 1'b0;
      total <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      err_q <= err_nx;
      if (count_vote) total <= total + VOTE_W'(1);
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    err_nx     = 1'b0;
    hold_clr   = 1'b0;
    hold_inc   = 1'b0;
    lock_clr   = 1'b0;
    lock_inc   = 1'b0;
    count_vote = 1'b0;
    case (state)
      IDLE: begin
        hold_clr = 1'b1;
        lock_clr = 1'b1;
        if (bus.ballot_start && !bus.mode) state_nx = ARMED;
      end
      ARMED: begin
        if (bus.mode) begin
          state_nx = IDLE;
          hold_clr = 1'b1;
          lock_clr = 1'b1;
        end else if (single) begin
          state_nx = HOLD;
          idx_nx   = btn_to_idx(btn);
          hold_clr = 1'b1;
          hold_inc = 1'b1;
        end else if (any_btn) begin
          err_nx = 1'b1;
        end
      end
      HOLD: begin
        if (bus.mode) begin
          state_nx = IDLE;
          hold_clr = 1'b1;
          lock_clr = 1'b1;
        end else if (!latched_only) begin
          state_nx = ARMED;
          hold_clr = 1'b1;
        end else if (hold_hit) begin
          state_nx = ISSUE;
          hold_clr = 1'b1;
        end else begin
          hold_inc = 1'b1;
        end
      end
      ISSUE: begin
        hold_clr = 1'b1;
        lock_clr = 1'b1;
        if (bus.mode) begin
          state_nx = IDLE;
        end else begin
          state_nx   = LOCKOUT;
          count_vote = 1'b1;
        end
      end
      LOCKOUT: begin
        // Any press restarts the release window, so a held button can never re-arm.
        if (bus.mode) begin
          state_nx = IDLE;
          hold_clr = 1'b1;
          lock_clr = 1'b1;
        end else if (any_btn) begin
          lock_clr = 1'b1;
        end else if (lock_hit) begin
          state_nx = IDLE;
          lock_clr = 1'b1;
        end else begin
          lock_inc = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign vote = ((state == ISSUE) && !bus.mode) ? (NUM_CAND'(1) << idx) : '0;

  assign bus.cand1_vote_valid = vote[0];
  assign bus.cand2_vote_valid = vote[1];
  assign bus.cand3_vote_valid = vote[2];
  assign bus.cand4_vote_valid = vote[3];
  assign bus.ballot_open      = (state == ARMED) || (state == HOLD);
  assign bus.busy             = (state != IDLE);
  assign bus.multi_press_err  = err_q;
  assign bus.total_votes      = total;

endmodule

// File: tb/tb_ballot_controller.sv
// Table-driven and sequence tests for ballot_controller with a vote scoreboard.
module tb_ballot_controller;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] sb[$];

  ballot_controller_if bus ();

  ballot_controller #(
    .HOLD_CYCLES    (4),
    .LOCKOUT_CYCLES (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       mode;
    logic       start;
    logic [3:0] btn;
    logic       busy;
    logic       open;
    logic       err;
    logic [3:0] votes;
    logic [7:0] total;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] votes();
    return {bus.cand4_vote_valid, bus.cand3_vote_valid, bus.cand2_vote_valid, bus.cand1_vote_valid};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic s, input logic [3:0] b);
    bus.mode         = m;
    bus.ballot_start = s;
    {bus.button4, bus.button3, bus.button2, bus.button1} = b;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic m, input logic s, input logic [3:0] b, input logic bz,
                     input logic op, input logic er, input logic [3:0] v, input logic [7:0] t);
    vec_t r;
    r.mode = m; r.start = s; r.btn = b; r.busy = bz; r.open = op;
    r.err = er; r.votes = v; r.total = t;
    tbl.push_back(r);
  endtask

  task automatic do_ballot(input int c, input logic [7:0] exp_total);
    drive(1'b0, 1'b1, 4'b0000);
    step();
    drive(1'b0, 1'b0, 4'(1 << c));
    sb.push_back(4'(1 << c));
    repeat (5) step();
    drive(1'b0, 1'b0, 4'b0000);
    repeat (9) step();
    check("ballot_back_idle", bus.busy, 1'b0);
    check("ballot_total", bus.total_votes, exp_total);
  endtask

  // Every vote pulse must be one-hot and match the next expected candidate.
  initial begin
    logic [3:0] v;
    logic [3:0] e;
    forever begin
      @(posedge clock);
      #2;
      v = votes();
      if (v != 4'b0000) begin
        check("vote_onehot", 32'($countones(v)), 32'd1);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_vote actual=%0h expected=none", v);
        end else begin
          e = sb.pop_front();
          check("sb_vote", v, e);
        end
      end
    end
  end

  initial begin
    logic [7:0] exp_total;

    reset = 1'b0;
    drive(1'b0, 1'b0, 4'b0000);
    #12;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_open", bus.ballot_open, 1'b0);
    check("rst_err", bus.multi_press_err, 1'b0);
    check("rst_votes", votes(), 4'b0000);
    check("rst_total", bus.total_votes, 8'd0);
    reset = 1'b1;
    step();

    // mode start btn    busy open err votes total
    add(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0);
    add(1, 1, 4'b0000, 0, 0, 0, 4'b0000, 0);
    add(0, 1, 4'b0000, 1, 1, 0, 4'b0000, 0);
    add(0, 0, 4'b1001, 1, 1, 1, 4'b0000, 0);
    add(0, 0, 4'b0000, 1, 1, 0, 4'b0000, 0);
    add(0, 0, 4'b0111, 1, 1, 1, 4'b0000, 0);
    add(0, 0, 4'b0010, 1, 1, 0, 4'b0000, 0);
    add(0, 0, 4'b0010, 1, 1, 0, 4'b0000, 0);
    add(0, 0, 4'b0110, 1, 1, 0, 4'b0000, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 4'b0010, 1, 1, 0, 4'b0000, 0);
    add(0, 0, 4'b0010, 1, 0, 0, 4'b0010, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1);
    add(0, 0, 4'b0001, 1, 0, 0, 4'b0000, 1);
    for (int i = 0; i < 7; i++) add(0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1);
    add(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 1);
    add(0, 0, 4'b0010, 0, 0, 0, 4'b0000, 1);
    add(0, 0, 4'b0010, 0, 0, 0, 4'b0000, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].mode, tbl[i].start, tbl[i].btn);
      if (tbl[i].votes != 4'b0000) sb.push_back(tbl[i].votes);
      step();
      check($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
      check($sformatf("tbl%0d_open", i), bus.ballot_open, tbl[i].open);
      check($sformatf("tbl%0d_err", i), bus.multi_press_err, tbl[i].err);
      check($sformatf("tbl%0d_votes", i), votes(), tbl[i].votes);
      check($sformatf("tbl%0d_total", i), bus.total_votes, tbl[i].total);
    end
    exp_total = 8'd1;

    // Bounce: a short press then release must not count.
    drive(0, 1, 4'b0000);
    step();
    drive(0, 0, 4'b0100);
    repeat (3) step();
    drive(0, 0, 4'b0000);
    step();
    check("bounce_rearmed", bus.ballot_open, 1'b1);
    drive(0, 0, 4'b0100);
    repeat (4) step();
    check("bounce_early", votes(), 4'b0000);
    sb.push_back(4'b0100);
    step();
    check("bounce_pulse", votes(), 4'b0100);
    drive(0, 0, 4'b0000);
    step();
    exp_total++;
    check("bounce_pulse_end", votes(), 4'b0000);
    check("bounce_total", bus.total_votes, exp_total);
    repeat (8) step();
    check("bounce_idle", bus.busy, 1'b0);

    // Mode abort during HOLD, then ballot_start ignored in display mode.
    drive(0, 1, 4'b0000);
    step();
    drive(0, 0, 4'b0001);
    repeat (2) step();
    drive(1, 0, 4'b0001);
    step();
    check("abort_busy", bus.busy, 1'b0);
    check("abort_votes", votes(), 4'b0000);
    check("abort_total", bus.total_votes, exp_total);
    drive(1, 1, 4'b0000);
    repeat (2) step();
    check("mode_start_ignored", bus.busy, 1'b0);
    drive(0, 0, 4'b0000);
    step();

    // Asynchronous reset mid-HOLD.
    drive(0, 1, 4'b0000);
    step();
    drive(0, 0, 4'b1000);
    repeat (3) step();
    check("prereset_open", bus.ballot_open, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    check("midhold_rst_busy", bus.busy, 1'b0);
    check("midhold_rst_open", bus.ballot_open, 1'b0);
    check("midhold_rst_total", bus.total_votes, 8'd0);
    check("midhold_rst_votes", votes(), 4'b0000);
    repeat (2) step();
    #3;
    reset = 1'b1;
    repeat (6) begin
      step();
      check("postreset_idle", bus.busy, 1'b0);
    end
    drive(0, 0, 4'b0000);
    step();

    // 256 complete ballots wrap the total back to zero.
    exp_total = 8'd0;
    for (int i = 0; i < 256; i++) begin
      exp_total++;
      do_ballot(i % 4, exp_total);
    end
    check("wrap_total", bus.total_votes, 8'd0);

    repeat (2) step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ballot_controller.md
BALLOT_CONTROLLER -- requirements
Module: ballot_controller

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: press-qualification length in clock edges; legal range 1..65535.
REQ-002 Parameter LOCKOUT_CYCLES, default 8: number of consecutive all-released edges required before the next ballot; legal range 1..65535.
REQ-003 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port mode, input, 1: 0 = voting, 1 = result display; the same signal that drives the vote logger.
REQ-006 Port ballot_start, input, 1: officer authorisation; sampled as a level in IDLE.
REQ-007 Ports button1..button4, input, 1 each: synchronised candidate buttons; 1 = pressed.
REQ-008 Ports cand1_vote_valid..cand4_vote_valid, output, 1 each: one-cycle vote pulses that drive the logger.
REQ-009 Port ballot_open, output, 1: high in ARMED or HOLD.
REQ-010 Port busy, output, 1: high in any state other than IDLE.
REQ-011 Port multi_press_err, output, 1: one-cycle pulse on a rejected multi-button press.
REQ-012 Port total_votes, output, 8: count of votes issued; wraps from 255 to 0.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, ARMED, HOLD, ISSUE, LOCKOUT.
REQ-014 IDLE SHALL move to ARMED on an edge where ballot_start=1 and mode=0. While mode=1, or while busy=1, ballot_start SHALL be ignored.
REQ-015 ARMED, exactly one button high: go to HOLD, latch the candidate index, set hold_cnt=1.
REQ-016 ARMED, two or more buttons high: pulse multi_press_err for one cycle, stay in ARMED, latch nothing.
REQ-017 ARMED, no button high: stay in ARMED (no timeout).
REQ-018 HOLD, latched button is the only one high and hold_cnt<HOLD_CYCLES: increment hold_cnt.
REQ-019 HOLD, latched button is the only one high and hold_cnt=HOLD_CYCLES: go to ISSUE.
REQ-020 HOLD, latched button released or any other button high: return to ARMED and clear hold_cnt; no error pulse.
REQ-021 Qualification SHALL require the button to be seen on HOLD_CYCLES+1 consecutive edges. The vote pulse SHALL appear in the cycle after the last qualifying edge.
REQ-022 ISSUE SHALL last exactly one cycle. The cand<n>_vote_valid for the latched index SHALL be high for that cycle; all other vote outputs SHALL stay 0.
REQ-023 In ISSUE, total_votes SHALL increment by 1 (mod 256), and the next state SHALL be LOCKOUT with lock_cnt=0.
REQ-024 LOCKOUT, any button high: clear lock_cnt.
REQ-025 LOCKOUT, all buttons released: increment lock_cnt. On the LOCKOUT_CYCLES-th consecutive released edge, go to IDLE.
REQ-026 mode=1 in ARMED, HOLD or LOCKOUT: go to IDLE on that edge and clear both counters. A vote in progress is discarded.
REQ-027 mode=1 in ISSUE: no vote pulse, no total_votes increment, next state IDLE. Vote outputs SHALL be gated by ~mode.
REQ-028 At most one cand<n>_vote_valid SHALL be high in any cycle.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, both counters 0, the latched index 0, total_votes 0, and every output 0, independent of clock.
REQ-030 Reset asserted mid-HOLD or mid-ISSUE SHALL produce no vote pulse. After reset release, the block SHALL wait for a new ballot_start.

Structure
REQ-031 Package vote_pkg SHALL hold the state enum, NUM_CAND=4, VOTE_W=8 and the candidate-index type; the vote logger shares the latter two.
REQ-032 Sub-module ballot_timer (16-bit clear/increment/compare counter) SHALL be instantiated once for hold_cnt and once for lock_cnt.
REQ-033 Vote outputs, ballot_open, busy and multi_press_err SHALL be decoded from registered state, gated only by mode.

Verification
REQ-034 Defaults. ballot_start=1 for 1 cycle, then button2 held 5 edges -> cand2_vote_valid high for exactly 1 cycle, total_votes=1, state LOCKOUT.
REQ-035 Bounce. ARMED, button3 held 3 edges, released, then held 5 edges -> exactly one cand3_vote_valid pulse, after the second press only.
REQ-036 Multi-press. ARMED, button1 and button4 high together -> multi_press_err for 1 cycle, no vote pulse, state ARMED.
REQ-037 Lockout. After a vote, buttons released 5 edges, button1 pressed, then released 8 edges -> IDLE only after those 8; no second vote without a new ballot_start.
REQ-038 Mode abort. mode=1 during HOLD -> IDLE next edge, no pulse, total_votes unchanged; ballot_start while mode=1 -> stays IDLE.
REQ-039 Wrap and reset. 256 complete ballots -> total_votes=0. reset=0 asserted mid-HOLD -> all outputs 0 immediately, no pulse.
